product_accumulator: RTL

Sequential multiply-accumulate back end that sits directly downstream of the 4x4 Wallace-tree multiplier. It consumes the 8-bit unsigned product stream through a valid/ready handshake and sums a programmed number of products (1–16) into a wide accumulator. It then presents the result with a one-cycle done pulse, which turns the combinational multiplier into a dot-product engine inside the same TinyTapeout top.

---
 rtl/product_acc_pkg.sv | 19 +
 rtl/product_acc_adder.sv | 32 +++
 rtl/product_accumulator.sv | 104 ++++++++++
 3 files changed

// File: rtl/product_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : product_acc_pkg
// Brief    : Shared constants and FSM state encoding for product_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package product_acc_pkg;

    localparam int c_ACC_W_DEFAULT = 12;
    localparam int c_LEN_W_DEFAULT = 4;
    localparam int c_PROD_W        = 8;

    localparam int c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_ACCUM = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/product_acc_adder.sv
`default_nettype none
// ============================================================================
// Module   : product_acc_adder
// Brief    : Combinational ACC_W+1 bit accumulate adder with carry out.
//            Clamps to all-ones on carry when SATURATE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module product_acc_adder
    import product_acc_pkg::*;
#(
    parameter int ACC_W = c_ACC_W_DEFAULT
) (
    input  logic [ACC_W-1:0]    i_acc,
    input  logic [c_PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]    o_sum,
    output logic                o_carry
);

    logic [ACC_W:0] w_wide;

    assign w_wide  = {1'b0, i_acc} + {{(ACC_W + 1 - c_PROD_W){1'b0}}, i_prod};
    assign o_carry = w_wide[ACC_W];

`ifdef SATURATE_EN
    // Once clamped, later adds carry again (or add zero), so the clamp sticks.
    assign o_sum = o_carry ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];
`else
    assign o_sum = w_wide[ACC_W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : product_accumulator
// Brief    : Valid/ready multiply-accumulate back end summing 1..2^LEN_W
//            unsigned 8-bit products. Optional macro: SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int ACC_W = c_ACC_W_DEFAULT,
    parameter int LEN_W = c_LEN_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic [c_PROD_W-1:0] prod,
    input  logic                prod_valid,
    output logic                prod_ready,
    output logic [ACC_W-1:0]    acc,
    output logic                done,
    output logic                busy,
    output logic                overflow
);

    localparam logic [LEN_W:0] c_FULL_LEN = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] c_ONE      = {{LEN_W{1'b0}}, 1'b1};

    logic [c_STATE_W-1:0] r_state;
    logic [LEN_W:0]       r_remaining;
    logic [ACC_W-1:0]     r_acc;
    logic                 r_done;
    logic                 r_busy;
    logic                 r_overflow;

    logic [ACC_W-1:0]     w_sum;
    logic                 w_carry;
    logic [LEN_W:0]       w_len_ext;

    product_acc_adder #(
        .ACC_W   (ACC_W)
    ) u_adder (
        .i_acc   (r_acc),
        .i_prod  (prod),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // A programmed length of zero stands for the full 2^LEN_W products.
    assign w_len_ext = (len == '0) ? c_FULL_LEN : {1'b0, len};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_remaining <= '0;
            r_acc       <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_acc       <= '0;
                        r_overflow  <= 1'b0;
                        r_remaining <= w_len_ext;
                        r_busy      <= 1'b1;
                        r_state     <= c_ST_ACCUM;
                    end
                end
                c_ST_ACCUM: begin
                    if (prod_valid) begin
                        r_acc       <= w_sum;
                        r_overflow  <= r_overflow | w_carry;
                        r_remaining <= r_remaining - c_ONE;
                        if (r_remaining == c_ONE) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign prod_ready = (r_state == c_ST_ACCUM);
    assign acc        = r_acc;
    assign done       = r_done;
    assign busy       = r_busy;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
